// File: rtl/alu_issue_stage.sv
// ID-stage issue register: decodes instruction + register operands into ALU code/operands for EX.
// Optional ISSUE_STATS_EN adds saturating issued/illegal counters.
module alu_issue_stage #(
    parameter int unsigned DATA_W = 32,
    parameter logic [3:0]  NOP_OP = 4'b0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] rsData,
    input  logic [DATA_W-1:0] rtData,
    input  logic              flush,
    output logic              outValid,
    input  logic              outReady,
    output logic [3:0]        aluOperand,
    output logic [DATA_W-1:0] aluInput1,
    output logic [DATA_W-1:0] aluInput2,
    output logic [4:0]        destReg,
    output logic              regWrite,
    output logic              memRead,
    output logic              memWrite,
`ifdef ISSUE_STATS_EN
    output logic [15:0]       issuedCount,
    output logic [15:0]       illegalCount,
`endif
    output logic              illegal
);

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000, ALU_SUB = 4'b0010, ALU_AND = 4'b0100, ALU_OR  = 4'b0101,
        ALU_NOR = 4'b0110, ALU_XOR = 4'b0111, ALU_SLL = 4'b1000, ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010
    } alu_op_e;

    logic [5:0]  opcode, funct;
    logic [4:0]  rt, rd, shamt;
    logic [15:0] imm;
    logic [DATA_W-1:0] imm_sx, imm_zx;

    assign opcode = instruction[31:26];
    assign rt     = instruction[20:16];
    assign rd     = instruction[15:11];
    assign shamt  = instruction[10:6];
    assign funct  = instruction[5:0];
    assign imm    = instruction[15:0];
    assign imm_sx = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_zx = {{(DATA_W-16){1'b0}}, imm};

    logic [3:0]        op_d, op_q;
    logic [DATA_W-1:0] in1_d, in1_q, in2_d, in2_q;
    logic [4:0]        dest_d, dest_q;
    logic              rw_d, rw_q, mr_d, mr_q, mw_d, mw_q, ill_d, ill_q;
    logic              valid_q;
    logic              accept;

    always_comb begin
        op_d   = NOP_OP;
        in1_d  = '0;
        in2_d  = '0;
        dest_d = '0;
        rw_d   = 1'b0;
        mr_d   = 1'b0;
        mw_d   = 1'b0;
        ill_d  = 1'b0;
        case (opcode)
            6'h00: begin
                dest_d = rd;
                rw_d   = 1'b1;
                in1_d  = rsData;
                in2_d  = rtData;
                case (funct)
                    6'h20, 6'h21: op_d = ALU_ADD;
                    6'h22, 6'h23: op_d = ALU_SUB;
                    6'h24:        op_d = ALU_AND;
                    6'h25:        op_d = ALU_OR;
                    6'h26:        op_d = ALU_XOR;
                    6'h27:        op_d = ALU_NOR;
                    6'h00, 6'h02, 6'h03: begin
                        op_d  = (funct == 6'h00) ? ALU_SLL : (funct == 6'h02) ? ALU_SRL : ALU_SRA;
                        in1_d = rtData;
                        in2_d = {{(DATA_W-5){1'b0}}, shamt};
                    end
                    6'h04, 6'h06, 6'h07: begin
                        op_d  = (funct == 6'h04) ? ALU_SLL : (funct == 6'h06) ? ALU_SRL : ALU_SRA;
                        in1_d = rtData;
                        in2_d = {{(DATA_W-5){1'b0}}, rsData[4:0]};
                    end
                    default: ill_d = 1'b1;
                endcase
            end
            6'h08, 6'h09: begin op_d = ALU_ADD; in1_d = rsData; in2_d = imm_sx; dest_d = rt; rw_d = 1'b1; end
            6'h0C:        begin op_d = ALU_AND; in1_d = rsData; in2_d = imm_zx; dest_d = rt; rw_d = 1'b1; end
            6'h0D:        begin op_d = ALU_OR;  in1_d = rsData; in2_d = imm_zx; dest_d = rt; rw_d = 1'b1; end
            6'h0E:        begin op_d = ALU_XOR; in1_d = rsData; in2_d = imm_zx; dest_d = rt; rw_d = 1'b1; end
            6'h0F:        begin op_d = ALU_SLL; in1_d = imm_zx; in2_d = DATA_W'(16); dest_d = rt; rw_d = 1'b1; end
            6'h23:        begin op_d = ALU_ADD; in1_d = rsData; in2_d = imm_sx; dest_d = rt; rw_d = 1'b1; mr_d = 1'b1; end
            6'h2B:        begin op_d = ALU_ADD; in1_d = rsData; in2_d = imm_sx; mw_d = 1'b1; end
            default:      ill_d = 1'b1;
        endcase
        // Illegal encodings issue as an inert bubble that EX turns into an exception.
        if (ill_d) begin
            op_d   = NOP_OP;
            in1_d  = '0;
            in2_d  = '0;
            dest_d = '0;
            rw_d   = 1'b0;
            mr_d   = 1'b0;
            mw_d   = 1'b0;
        end
        if (dest_d == 5'd0) rw_d = 1'b0;
    end

    assign inReady = !valid_q || outReady;
    assign accept  = inValid && inReady && !flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            op_q    <= NOP_OP;
            in1_q   <= '0;
            in2_q   <= '0;
            dest_q  <= '0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            mr_q    <= 1'b0;
            mw_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            op_q    <= op_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            dest_q  <= dest_d;
            rw_q    <= rw_d;
            mr_q    <= mr_d;
            mw_q    <= mw_d;
            ill_q   <= ill_d;
        end else if (valid_q && outReady) begin
            valid_q <= 1'b0;
        end
    end

`ifdef ISSUE_STATS_EN
    logic [15:0] issued_q, illcnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            issued_q <= '0;
            illcnt_q <= '0;
        end else if (accept) begin
            if (issued_q != '1) issued_q <= issued_q + 16'd1;
            if (ill_d && illcnt_q != '1) illcnt_q <= illcnt_q + 16'd1;
        end
    end

    assign issuedCount  = issued_q;
    assign illegalCount = illcnt_q;
`endif

    assign outValid   = valid_q;
    assign aluOperand = op_q;
    assign aluInput1  = in1_q;
    assign aluInput2  = in2_q;
    assign destReg    = dest_q;
    assign regWrite   = rw_q;
    assign memRead    = mr_q;
    assign memWrite   = mw_q;
    assign illegal    = ill_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream end of the ALU operand/opcode interface.
- Decodes a fetched MIPS-style instruction plus register-file read data into the 4-bit ALU operation code and the two 32-bit ALU inputs.
- Holds the result in the ID/EX pipeline register, using a valid/ready handshake toward EX.
- Sits between the ID-stage register-file read and the EX-stage ALU of the 5-stage pipeline.

Parameters:
- DATA_W, 32, datapath width of ALU inputs; only 32 is supported.
- NOP_OP, 4'b0000, ALU code driven while the stage holds a bubble or an illegal instruction.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous active-low reset.
- instruction  input  32  instruction word from IF/ID.
- inValid  input  1  instruction/rsData/rtData are valid this cycle.
- inReady  output  1  stage accepts an instruction this cycle.
- rsData  input  32  register-file value of instruction[25:21].
- rtData  input  32  register-file value of instruction[20:16].
- flush  input  1  kill the held entry and any incoming instruction (branch redirect).
- outValid  output  1  ID/EX register holds a live instruction.
- outReady  input  1  EX consumes the entry this cycle.
- aluOperand  output  4  ALU operation code.
- aluInput1  output  32  ALU first operand.
- aluInput2  output  32  ALU second operand.
- destReg  output  5  writeback register index.
- regWrite  output  1  instruction writes destReg.
- memRead  output  1  load.
- memWrite  output  1  store.
- illegal  output  1  unsupported encoding was accepted.

Behaviour:
- Reset (rst=0, async): outValid=0, aluOperand=NOP_OP, aluInput1=0, aluInput2=0, destReg=0, regWrite=0, memRead=0, memWrite=0, illegal=0.
- inReady = !outValid || outReady. This is combinational, and flush does not affect it.
- Accept happens when inValid && inReady && !flush. On the next edge all outputs load and outValid=1. Latency is one cycle.
- If outValid && outReady and there is no accept: outValid goes to 0 and the data outputs hold their last values.
- If outValid && !outReady: all outputs hold, regardless of inValid.
- flush has priority over everything. On the next edge outValid=0, and regWrite, memRead, memWrite and illegal all go to 0.
- ALU codes:
  - 0000 add
  - 0010 sub
  - 0100 and
  - 0101 or
  - 0110 nor
  - 0111 xor
  - 1000 shift-left
  - 1001 shift-right-logical
  - 1010 shift-right-arithmetic
- R-type (opcode 0x00): destReg=rd, regWrite=1, by funct:
  - 0x20/0x21 add; 0x22/0x23 sub; 0x24 and; 0x25 or; 0x26 xor; 0x27 nor. For these, input1=rsData and input2=rtData.
  - 0x00 sll, 0x02 srl, 0x03 sra: input1=rtData, input2={27'b0, shamt}.
  - 0x04 sllv, 0x06 srlv, 0x07 srav: input1=rtData, input2={27'b0, rsData[4:0]}.
- I-type: destReg=rt, input1=rsData.
  - 0x08/0x09 addi/addiu: add, sign-extended imm.
  - 0x0C andi, 0x0D ori, 0x0E xori: zero-extended imm.
  - 0x0F lui: input1={16'b0, imm}, input2=16, code 1000.
  - 0x23 lw: add, sign-extended imm, memRead=1.
  - 0x2B sw: add, sign-extended imm, memWrite=1, regWrite=0, destReg=0.
- Any destReg of 0 forces regWrite=0.
- Any other opcode or funct: illegal=1, aluOperand=NOP_OP, inputs=0, regWrite=memRead=memWrite=0, outValid=1 (EX raises the exception).
- Reset asserted mid-handshake: the entry is dropped immediately, with no partial update.

Optional Feature:
- Macro ISSUE_STATS_EN.
- When defined, adds two outputs, issuedCount[15:0] and illegalCount[15:0].
  - issuedCount increments on every accept.
  - illegalCount increments on every accept whose encoding is illegal.
  - Both saturate at 0xFFFF, clear on reset, and are unaffected by flush (a flush cycle is not an accept).
- When undefined, neither port exists and no counter logic is present.

Test Plan:
- 0x00221820 (add $3,$1,$2), rsData=5, rtData=7, outReady=1 -> next cycle: outValid=1, aluOperand=0000, aluInput1=5, aluInput2=7, destReg=3, regWrite=1.
- 0x2024FFFF (addi $4,$1,-1), rsData=10 -> aluOperand=0000, aluInput1=10, aluInput2=0xFFFFFFFF, destReg=4.
- 0x00031100 (sll $2,$3,4), rtData=0x0F -> aluOperand=1000, aluInput1=0x0F, aluInput2=4, destReg=2. Separately, 0x3C051234 (lui $5,0x1234) -> aluInput1=0x1234, aluInput2=16, aluOperand=1000.
- outReady=0 with a held entry, new instruction offered -> inReady=0 and outputs unchanged for 3 cycles. Then outReady=1 -> new entry loads on the same edge the old one is consumed.
- flush together with inValid=1 -> next cycle outValid=0 and regWrite=0. Then rst pulsed low while outValid=1 -> outputs return to reset values immediately (asynchronously).
- 0xFC000000 (opcode 0x3F) -> illegal=1, regWrite=0, aluOperand=0000. With ISSUE_STATS_EN, illegalCount=1 and issuedCount=1.
